mmio_uart_hub: RTL and testbench

Synthesizable memory-mapped I/O hub on the processor data bus, decoding the 0xf0000000 region. Provides a sticky halt register and NCH independent 8N1 UART transmit channels, each with a TX FIFO and a programmable baud divider. Existing software stays compatible: a halt write goes to 0xf0000000, a byte write goes to 0xf0000100, and a TX-ready poll reads 0xf0000100.

---
 rtl/mmio_pkg.sv | 39 +++
 rtl/uart_tx_ch.sv | 187 ++++++++++++++++++
 rtl/mmio_uart_hub.sv | 138 +++++++++++++
 tb/tb_mmio_uart_hub.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO hub: address map, STATUS layout, TX state encoding.
package mmio_pkg;

    localparam logic [3:0]  REGION     = 4'hf;
    localparam logic [15:0] HALT_ADDR  = 16'h0000;
    localparam logic [15:0] CH_BASE    = 16'h0100;
    localparam logic [7:0]  DATA_OFS   = 8'h00;
    localparam logic [7:0]  STATUS_OFS = 8'h04;
    localparam logic [7:0]  DIV_OFS    = 8'h08;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_BUSY      = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] status_word(input logic [7:0] count,
                                                input logic       ovf,
                                                input logic       busy,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] s;
        s                       = '0;
        s[ST_EMPTY]             = empty;
        s[ST_FULL]              = full;
        s[ST_BUSY]              = busy;
        s[ST_OVF]               = ovf;
        s[ST_COUNT_LSB +: 8]    = count;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_ch.sv
// One 8N1 UART transmit channel: TX FIFO, divider register and bit-timing FSM.
//
// state    | meaning
// ---------+------------------------------------------------------------
// TX_IDLE  | line high, waiting for the FIFO to hold a byte
// TX_START | start bit (tx=0) for div cycles
// TX_DATA  | data bits 0..7, LSB first, div cycles each
// TX_STOP  | stop bit (tx=1); chains straight into the next frame if queued
module uart_tx_ch
    import mmio_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DIV_RESET = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  wdata,
    input  logic        div_we,
    input  logic [15:0] div_wdata,
    input  logic        ovf_clr,
    output logic [7:0]  count,
    output logic        full,
    output logic        empty,
    output logic        ovf,
    output logic        busy,
    output logic [15:0] div,
    output logic        tx
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   div_q, div_d;

    tx_state_e     state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [15:0]   cur_div_q, cur_div_d;
    logic          tx_q, tx_d;

    logic          full_w, empty_w, push_ok, pop, load_frame;

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);
    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is lost.
    assign push_ok = push && !full_w;

    // FIFO pointers, occupancy, overflow flag and divider register.
    always_comb begin
        wptr_d  = push_ok ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop     ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (ovf_clr)
            ovf_d = 1'b0;
        if (push && full_w)
            ovf_d = 1'b1;
        div_d = div_q;
        if (div_we)
            div_d = (div_wdata == 16'd0) ? 16'd1 : div_wdata;
    end

    // Bit-timing FSM; timer counts down from div-1 and the bit ends at zero.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        cur_div_d  = cur_div_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        load_frame = 1'b0;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!empty_w)
                    load_frame = 1'b1;
            end
            TX_START: begin
                if (timer_q == 16'd0) begin
                    state_d = TX_DATA;
                    timer_d = cur_div_q - 16'd1;
                    tx_d    = shreg_q[0];
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (timer_q == 16'd0) begin
                    timer_d = cur_div_q - 16'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (timer_q == 16'd0) begin
                    if (!empty_w) begin
                        load_frame = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Frame load: divider is latched here so later DIV writes leave this frame alone.
        if (load_frame) begin
            pop       = 1'b1;
            state_d   = TX_START;
            shreg_d   = mem_q[rptr_q];
            cur_div_d = div_q;
            timer_d   = div_q - 16'd1;
            bit_cnt_d = 3'd0;
            tx_d      = 1'b0;
        end
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wptr_q] <= wdata;
    end

    // Control state register; reset drives tx high without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            div_q     <= 16'(DIV_RESET);
            state_q   <= TX_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            cur_div_q <= 16'(DIV_RESET);
            tx_q      <= 1'b1;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            cur_div_q <= cur_div_d;
            tx_q      <= tx_d;
        end
    end

    assign count = 8'(count_q);
    assign full  = full_w;
    assign empty = empty_w;
    assign ovf   = ovf_q;
    assign busy  = (state_q != TX_IDLE);
    assign div   = div_q;
    assign tx    = tx_q;

endmodule

// File: rtl/mmio_uart_hub.sv
// MMIO hub at 0xf0000000: address decode, sticky HALT register, registered read mux.
module mmio_uart_hub
    import mmio_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int DEPTH     = 16,
    parameter int DIV_RESET = 868
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     mem_addr,
    input  logic            mem_oe,
    input  logic [3:0]      mem_we,
    input  logic [31:0]     mem_wdata,
    output logic [31:0]     mem_rdata,
    output logic            mem_valid,
    output logic            halt,
    output logic [31:0]     halt_code,
    output logic [NCH-1:0]  tx
);

    logic        sel, wr, rd;
    logic [15:0] addr16;
    logic        unused_addr_bits;

    logic [NCH-1:0] ch_push, ch_div_we, ch_ovf_clr;
    logic [NCH-1:0] ch_full, ch_empty, ch_ovf, ch_busy;
    logic [7:0]     ch_count [NCH];
    logic [15:0]    ch_div   [NCH];

    logic        halt_q, halt_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic [31:0] rdata_q, rdata_d;
    logic        valid_q, valid_d;

    assign sel              = mem_oe && (mem_addr[31:28] == REGION);
    assign wr               = sel && (mem_we != 4'b0000);
    assign rd               = sel && (mem_we == 4'b0000);
    assign addr16           = mem_addr[15:0];
    assign unused_addr_bits = ^mem_addr[27:16];

    // Per-channel strobes: DATA push, DIV write, and the STATUS read that clears ovf.
    always_comb begin
        logic [15:0] ch_base;
        ch_push    = '0;
        ch_div_we  = '0;
        ch_ovf_clr = '0;
        ch_base    = '0;
        for (int n = 0; n < NCH; n++) begin
            ch_base = 16'((n + 1) * CH_BASE);
            if (addr16[15:8] == ch_base[15:8]) begin
                case (addr16[7:0])
                    DATA_OFS:   ch_push[n]    = wr && mem_we[0];
                    STATUS_OFS: ch_ovf_clr[n] = rd;
                    DIV_OFS:    ch_div_we[n]  = wr;
                    default:    ;
                endcase
            end
        end
    end

    // HALT latches once and ignores further writes until reset.
    always_comb begin
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        if (wr && (addr16 == HALT_ADDR) && !halt_q) begin
            halt_d      = 1'b1;
            halt_code_d = mem_wdata;
        end
    end

    // Read mux; unmapped reads still respond, with zero data.
    always_comb begin
        logic [15:0] ch_base;
        rdata_d = '0;
        valid_d = rd;
        ch_base = '0;
        if (rd) begin
            if (addr16 == HALT_ADDR)
                rdata_d = {31'b0, halt_q};
            for (int n = 0; n < NCH; n++) begin
                ch_base = 16'((n + 1) * CH_BASE);
                if (addr16[15:8] == ch_base[15:8]) begin
                    case (addr16[7:0])
                        DATA_OFS:   rdata_d = {31'b0, !ch_full[n]};
                        STATUS_OFS: rdata_d = status_word(ch_count[n], ch_ovf[n], ch_busy[n],
                                                          ch_full[n], ch_empty[n]);
                        DIV_OFS:    rdata_d = {16'b0, ch_div[n]};
                        default:    rdata_d = '0;
                    endcase
                end
            end
        end
    end

    // Bus-facing registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            rdata_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            rdata_q     <= rdata_d;
            valid_q     <= valid_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        uart_tx_ch #(
            .DEPTH     (DEPTH),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .push      (ch_push[g]),
            .wdata     (mem_wdata[7:0]),
            .div_we    (ch_div_we[g]),
            .div_wdata (mem_wdata[15:0]),
            .ovf_clr   (ch_ovf_clr[g]),
            .count     (ch_count[g]),
            .full      (ch_full[g]),
            .empty     (ch_empty[g]),
            .ovf       (ch_ovf[g]),
            .busy      (ch_busy[g]),
            .div       (ch_div[g]),
            .tx        (tx[g])
        );
    end

    assign mem_rdata = rdata_q;
    assign mem_valid = valid_q;
    assign halt      = halt_q;
    assign halt_code = halt_code_q;

endmodule

// File: tb/tb_mmio_uart_hub.sv
// Directed bench for mmio_uart_hub: bus decode, HALT, UART framing, FIFO overflow, async reset.
module tb_mmio_uart_hub;

    localparam int NCH = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [31:0]    mem_addr = '0;
    logic           mem_oe = 1'b0;
    logic [3:0]     mem_we = '0;
    logic [31:0]    mem_wdata = '0;
    logic [31:0]    mem_rdata;
    logic           mem_valid;
    logic           halt;
    logic [31:0]    halt_code;
    logic [NCH-1:0] tx;

    int total = 0;
    int bad   = 0;

    mmio_uart_hub #(.NCH(NCH), .DEPTH(16), .DIV_RESET(868)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .halt      (halt),
        .halt_code (halt_code),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Returns at the falling edge after the write edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = d;
        mem_we    = we;
        mem_oe    = 1'b1;
        @(negedge clk);
        mem_oe    = 1'b0;
        mem_we    = '0;
    endtask

    // Samples the response at the falling edge after the request edge.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        mem_addr = a;
        mem_we   = '0;
        mem_oe   = 1'b1;
        @(negedge clk);
        mem_oe   = 1'b0;
        d        = mem_rdata;
        v        = mem_valid;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        repeat (3) @(negedge clk);
        total++; if (tx !== 2'b11) begin bad++; $display("FAIL reset_tx: got %b expected 11", tx); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b expected 0", halt); end
        total++; if (halt_code !== 32'h0) begin bad++; $display("FAIL reset_halt_code: got %h expected 0", halt_code); end
        total++; if (mem_valid !== 1'b0 || mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_bus: got valid=%b rdata=%h expected 0/0", mem_valid, mem_rdata); end
        rst = 1'b1;
        bus_read(32'hf000_0104, d, v);
        total++; if (v !== 1'b1 || d !== 32'h0000_0001) begin bad++; $display("FAIL reset_status0: got v=%b d=%h expected 1/00000001", v, d); end
        bus_read(32'hf000_0108, d, v);
        total++; if (d !== 32'd868) begin bad++; $display("FAIL reset_div0: got %0d expected 868", d); end
        bus_read(32'hf000_0100, d, v);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL reset_data_rd: got %h expected 1", d); end
        bus_read(32'hf000_0204, d, v);
        total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL reset_status1: got %h expected 00000001", d); end
    endtask

    task automatic test_frame();
        logic [31:0] d;
        logic        v;
        logic [7:0]  byt;
        logic        exp;
        int          b;
        byt = 8'h41;
        bus_write(32'hf000_0108, 32'd4, 4'hf);
        bus_write(32'hf000_0100, 32'h41, 4'h1);
        total++; if (tx[0] !== 1'b1) begin bad++; $display("FAIL frame_pre_idle: got %b expected 1", tx[0]); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            b   = i / 4;
            exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byt[b-1];
            total++; if (tx[0] !== exp) begin bad++; $display("FAIL frame_bit cycle %0d: got %b expected %b", i, tx[0], exp); end
        end
        @(negedge clk);
        total++; if (tx[0] !== 1'b1) begin bad++; $display("FAIL frame_post_idle: got %b expected 1", tx[0]); end
        bus_read(32'hf000_0104, d, v);
        total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL frame_status_done: got %h expected 00000001", d); end
    endtask

    task automatic test_halt();
        logic [31:0] d;
        logic        v;
        bus_write(32'hf000_0000, 32'h0000_002a, 4'hf);
        total++; if (halt !== 1'b1) begin bad++; $display("FAIL halt_set: got %b expected 1", halt); end
        total++; if (halt_code !== 32'h2a) begin bad++; $display("FAIL halt_code: got %h expected 0000002a", halt_code); end
        bus_write(32'hf000_0000, 32'd5, 4'hf);
        total++; if (halt_code !== 32'h2a) begin bad++; $display("FAIL halt_sticky: got %h expected 0000002a", halt_code); end
        bus_read(32'hf000_0000, d, v);
        total++; if (v !== 1'b1 || d !== 32'h1) begin bad++; $display("FAIL halt_read: got v=%b d=%h expected 1/00000001", v, d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic        v;
        bus_read(32'hf000_0e00, d, v);
        total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL unmapped_ch: got v=%b d=%h expected 1/0", v, d); end
        @(negedge clk);
        total++; if (mem_valid !== 1'b0 || mem_rdata !== 32'h0) begin bad++; $display("FAIL valid_one_cycle: got v=%b d=%h expected 0/0", mem_valid, mem_rdata); end
        bus_read(32'hf000_0040, d, v);
        total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL unmapped_low: got v=%b d=%h expected 1/0", v, d); end
        bus_read(32'h1000_0100, d, v);
        total++; if (v !== 1'b0) begin bad++; $display("FAIL out_of_region: got v=%b expected 0", v); end
        bus_write(32'hf000_0208, 32'd0, 4'hf);
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL write_no_valid: got %b expected 0", mem_valid); end
        bus_read(32'hf000_0208, d, v);
        total++; if (d !== 32'd1) begin bad++; $display("FAIL div_zero_is_one: got %0d expected 1", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        v;
        logic [7:0]  bytes [3];
        bytes[0] = 8'h55;
        bytes[1] = 8'hA3;
        bytes[2] = 8'h0F;
        bus_write(32'hf000_0208, 32'd2, 4'hf);
        fork
            begin
                @(negedge clk);
                mem_addr  = 32'hf000_0200;
                mem_we    = 4'h1;
                mem_wdata = {24'b0, bytes[0]};
                mem_oe    = 1'b1;
                @(negedge clk);
                mem_wdata = {24'b0, bytes[1]};
                @(negedge clk);
                mem_wdata = {24'b0, bytes[2]};
                @(negedge clk);
                mem_oe    = 1'b0;
                mem_we    = '0;
            end
            begin
                logic [7:0] cur;
                logic       exp;
                int         b, f, p;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 60; i++) begin
                    @(negedge clk);
                    b   = i / 2;
                    f   = b / 10;
                    p   = b % 10;
                    cur = bytes[f];
                    exp = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : cur[p-1];
                    total++; if (tx[1] !== exp) begin bad++; $display("FAIL b2b_bit cycle %0d: got %b expected %b", i, tx[1], exp); end
                end
            end
        join
        @(negedge clk);
        bus_read(32'hf000_0204, d, v);
        total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL b2b_status_done: got %h expected 00000001", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic        v;
        bus_write(32'hf000_0108, 32'h0000_ffff, 4'hf);
        // The first byte is taken by the idle transmitter, so 18 pushes are one past full.
        for (int i = 0; i < 18; i++)
            bus_write(32'hf000_0100, 32'(i), 4'h1);
        total++; if (tx[0] !== 1'b0) begin bad++; $display("FAIL ovf_stalled_start: got %b expected 0", tx[0]); end
        bus_read(32'hf000_0104, d, v);
        total++; if (d !== 32'h0000_100e) begin bad++; $display("FAIL ovf_status: got %h expected 0000100e", d); end
        bus_read(32'hf000_0104, d, v);
        total++; if (d !== 32'h0000_1006) begin bad++; $display("FAIL ovf_cleared: got %h expected 00001006", d); end
        bus_read(32'hf000_0100, d, v);
        total++; if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL ovf_data_rd: got v=%b d=%h expected 1/0", v, d); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic        v;
        bus_write(32'hf000_0208, 32'd4, 4'hf);
        bus_write(32'hf000_0200, 32'h00, 4'h1);
        repeat (6) @(negedge clk);
        total++; if (tx !== 2'b00) begin bad++; $display("FAIL arst_pre: got %b expected 00", tx); end
        #2 rst = 1'b0;
        #1;
        total++; if (tx !== 2'b11) begin bad++; $display("FAIL arst_tx_async: got %b expected 11", tx); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL arst_halt: got %b expected 0", halt); end
        @(negedge clk);
        rst = 1'b1;
        bus_read(32'hf000_0104, d, v);
        total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL arst_status0: got %h expected 00000001", d); end
        bus_read(32'hf000_0108, d, v);
        total++; if (d !== 32'd868) begin bad++; $display("FAIL arst_div0: got %0d expected 868", d); end
        bus_read(32'hf000_0204, d, v);
        total++; if (d !== 32'h0000_0001) begin bad++; $display("FAIL arst_status1: got %h expected 00000001", d); end
        bus_read(32'hf000_0208, d, v);
        total++; if (d !== 32'd868) begin bad++; $display("FAIL arst_div1: got %0d expected 868", d); end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++; if (tx !== 2'b11) begin bad++; $display("FAIL arst_quiet cycle %0d: got %b expected 11", i, tx); end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_halt();
        test_unmapped();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
